// File: rtl/glitch_sequencer.sv
// ----------------------------------------------------------------------------
// glitch_sequencer
// Shot controller for the glitcher. One shot: hold the target in reset, release
// it, optionally wait for a target trigger rising edge, wait a programmable
// delay, then fire a glitch pulse of programmable width.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   start_i           begin a shot (sampled only in IDLE)
//   abort_i           cancel a shot in progress (returns to IDLE, no done)
//   use_trigger_i     1 = wait for a trigger rising edge before the delay
//   trigger_i         asynchronous trigger from the target
//   delay_cfg_i       cycles between reference point and glitch start
//   width_cfg_i       glitch pulse length in cycles (0 = no pulse)
//   target_rst_n_o    target reset, active low
//   glitch_out_o      glitch drive, active high
//   busy_o            shot in progress
//   done_o            one-cycle pulse at shot completion
//   timeout_o         sticky: last shot ended without a trigger
//   glitch_count_o    completed glitch pulses (wraps)
//   state_dbg_o       encoded current state
//
// state  | meaning
// IDLE   | waiting for start
// RESET  | target held in reset for RESET_CYCLES
// ARM    | waiting for synced trigger rising edge (bounded by TIMEOUT_CYCLES)
// DELAY  | counting delay_cfg cycles
// GLITCH | glitch_out high for width_cfg cycles
// FINISH | done pulse, back to IDLE
// ----------------------------------------------------------------------------
module glitch_sequencer #(
    parameter int RESET_CYCLES   = 120,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 1200000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             use_trigger_i,
    input  logic             trigger_i,
    input  logic [CNT_W-1:0] delay_cfg_i,
    input  logic [CNT_W-1:0] width_cfg_i,
    output logic             target_rst_n_o,
    output logic             glitch_out_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [15:0]      glitch_count_o,
    output logic [2:0]       state_dbg_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RESET  = 3'd1,
        S_ARM    = 3'd2,
        S_DELAY  = 3'd3,
        S_GLITCH = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] delay_q;
    logic [CNT_W-1:0] width_q;
    logic             use_trig_q;
    logic             trig_s1_q, trig_s2_q, trig_prev_q;
    logic             rst_n_q, glitch_q, busy_q, done_q, timeout_q;
    logic [15:0]      count_q;

    logic   trig_edge;
    state_t post_delay_st;
    state_t delay_entry_st;

    assign trig_edge = trig_s2_q & ~trig_prev_q;

    // Zero-length phases are skipped so that delay_cfg=0 and width_cfg=0 add no
    // cycles: the state after the delay is GLITCH or straight to FINISH, and
    // entering the delay phase may jump past DELAY entirely.
    assign post_delay_st  = (width_q == '0) ? S_FINISH : S_GLITCH;
    assign delay_entry_st = (delay_q == '0) ? post_delay_st : S_DELAY;

    // Synchronizer and edge-detect history always run, so a level that is
    // already high when ARM is entered never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_s1_q   <= 1'b0;
            trig_s2_q   <= 1'b0;
            trig_prev_q <= 1'b0;
        end else begin
            trig_s1_q   <= trigger_i;
            trig_s2_q   <= trig_s1_q;
            trig_prev_q <= trig_s2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            delay_q    <= '0;
            width_q    <= '0;
            use_trig_q <= 1'b0;
            rst_n_q    <= 1'b1;
            glitch_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q != S_IDLE && abort_i) begin
                state_q  <= S_IDLE;
                cnt_q    <= '0;
                rst_n_q  <= 1'b1;
                glitch_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_i && !abort_i) begin
                            delay_q    <= delay_cfg_i;
                            width_q    <= width_cfg_i;
                            use_trig_q <= use_trigger_i;
                            timeout_q  <= 1'b0;
                            busy_q     <= 1'b1;
                            rst_n_q    <= 1'b0;
                            cnt_q      <= '0;
                            state_q    <= S_RESET;
                        end
                    end
                    S_RESET: begin
                        if (cnt_q == RST_LAST) begin
                            rst_n_q <= 1'b1;
                            cnt_q   <= '0;
                            if (use_trig_q) begin
                                state_q <= S_ARM;
                            end else begin
                                state_q  <= delay_entry_st;
                                glitch_q <= (delay_entry_st == S_GLITCH);
                                done_q   <= (delay_entry_st == S_FINISH);
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_ARM: begin
                        if (trig_edge) begin
                            cnt_q    <= '0;
                            state_q  <= delay_entry_st;
                            glitch_q <= (delay_entry_st == S_GLITCH);
                            done_q   <= (delay_entry_st == S_FINISH);
                        end else if (cnt_q == TO_LAST) begin
                            cnt_q     <= '0;
                            timeout_q <= 1'b1;
                            done_q    <= 1'b1;
                            state_q   <= S_FINISH;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_DELAY: begin
                        // delay_q >= 1 here, so delay_q - 1 cannot wrap.
                        if (cnt_q == delay_q - 1'b1) begin
                            cnt_q    <= '0;
                            state_q  <= post_delay_st;
                            glitch_q <= (post_delay_st == S_GLITCH);
                            done_q   <= (post_delay_st == S_FINISH);
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_GLITCH: begin
                        if (cnt_q == width_q - 1'b1) begin
                            cnt_q    <= '0;
                            glitch_q <= 1'b0;
                            count_q  <= count_q + 1'b1;
                            done_q   <= 1'b1;
                            state_q  <= S_FINISH;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_FINISH: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q  <= S_IDLE;
                        cnt_q    <= '0;
                        rst_n_q  <= 1'b1;
                        glitch_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign target_rst_n_o = rst_n_q;
    assign glitch_out_o   = glitch_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign timeout_o      = timeout_q;
    assign glitch_count_o = count_q;
    assign state_dbg_o    = state_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// ----------------------------------------------------------------------------
// tb_glitch_sequencer
// Directed bench for glitch_sequencer with RESET_CYCLES=4, TIMEOUT_CYCLES=50.
// Cycle numbering: cycle 0 is the cycle in which start is driven (sampled at
// the edge ending it); outputs are sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_glitch_sequencer;

    localparam int R  = 4;
    localparam int TO = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort, use_trigger, trigger;
    logic [31:0] delay_cfg, width_cfg;
    logic        target_rst_n, glitch_out, busy, done, timeout;
    logic [15:0] glitch_count;
    logic [2:0]  state_dbg;

    int errors = 0;
    int checks = 0;
    int exp_count = 0;

    glitch_sequencer #(
        .RESET_CYCLES  (R),
        .CNT_W         (32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .abort_i       (abort),
        .use_trigger_i (use_trigger),
        .trigger_i     (trigger),
        .delay_cfg_i   (delay_cfg),
        .width_cfg_i   (width_cfg),
        .target_rst_n_o(target_rst_n),
        .glitch_out_o  (glitch_out),
        .busy_o        (busy),
        .done_o        (done),
        .timeout_o     (timeout),
        .glitch_count_o(glitch_count),
        .state_dbg_o   (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    // Non-trigger shot: target reset low in 1..R, glitch high in
    // R+1+d .. R+d+w, done at R+1+d+w, busy from 1 through done.
    // Config is scrambled after latching and must have no effect.
    task automatic shot_plain(input int d, input int w, input int extra_start);
        int done_c;
        done_c      = R + 1 + d + w;
        delay_cfg   = d;
        width_cfg   = w;
        use_trigger = 1'b0;
        for (int c = 0; c <= done_c + 1; c++) begin
            start = (c == 0) || (c == extra_start);
            if (c == 2) begin
                delay_cfg   = 32'd7;
                width_cfg   = 32'd9;
                use_trigger = 1'b1;
            end
            chk("rst_n", c, target_rst_n, (c >= 1 && c <= R) ? 1'b0 : 1'b1);
            chk("glitch", c, glitch_out, (c >= R + 1 + d && c <= R + d + w));
            chk("busy", c, busy, (c >= 1 && c <= done_c));
            chk("done", c, done, (c == done_c));
            tick();
        end
        start       = 1'b0;
        use_trigger = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; use_trigger = 1'b0; trigger = 1'b0;
        delay_cfg = '0; width_cfg = '0;
        tick(); tick();
        chk("rst_rst_n", 0, target_rst_n, 1'b1);
        chk("rst_glitch", 0, glitch_out, 1'b0);
        chk("rst_busy", 0, busy, 1'b0);
        chk("rst_done", 0, done, 1'b0);
        chk("rst_timeout", 0, timeout, 1'b0);
        chk("rst_count", 0, glitch_count, 16'd0);
        chk("rst_state", 0, state_dbg, 3'd0);
        rst = 1'b0;
        tick();

        // Basic non-trigger shot d=3 w=2: glitch 8-9, done 10
        shot_plain(3, 2, -1);
        exp_count = 1;
        chk("t1_count", 0, glitch_count, exp_count);
        chk("t1_state", 0, state_dbg, 3'd0);

        // Same shot with a stray start at cycle 6: identical waveform
        shot_plain(3, 2, 6);
        exp_count = 2;
        chk("t6_count", 0, glitch_count, exp_count);

        // d=0 w=0: no pulse, done at cycle 5
        shot_plain(0, 0, -1);
        chk("t2_count", 0, glitch_count, exp_count);
        chk("t2_timeout", 0, timeout, 1'b0);

        // Trigger mode: level high before ARM, low in 10..12, high from 13.
        // Synced edge detected at E=15, glitch at E+6=21, done at 22.
        trigger = 1'b1;
        tick(); tick(); tick(); tick();
        use_trigger = 1'b1; delay_cfg = 32'd5; width_cfg = 32'd1;
        for (int c = 0; c <= 23; c++) begin
            start   = (c == 0);
            trigger = !(c >= 10 && c <= 12);
            if (c == 9)  chk("t3_state_arm", c, state_dbg, 3'd2);
            if (c == 16) chk("t3_state_delay", c, state_dbg, 3'd3);
            chk("t3_glitch", c, glitch_out, (c == 21));
            chk("t3_done", c, done, (c == 22));
            tick();
        end
        start = 1'b0; trigger = 1'b0; use_trigger = 1'b0;
        exp_count = 3;
        chk("t3_count", 0, glitch_count, exp_count);
        chk("t3_timeout", 0, timeout, 1'b0);
        tick(); tick(); tick();

        // Trigger mode with no trigger: ARM 5..54, timeout/done at 55
        use_trigger = 1'b1; delay_cfg = 32'd2; width_cfg = 32'd2;
        for (int c = 0; c <= 56; c++) begin
            start = (c == 0);
            chk("t4_glitch", c, glitch_out, 1'b0);
            chk("t4_done", c, done, (c == 55));
            chk("t4_timeout", c, timeout, (c >= 55));
            tick();
        end
        start = 1'b0;
        chk("t4_count", 0, glitch_count, exp_count);

        // Next start clears timeout; abort during RESET
        use_trigger = 1'b0;
        start = 1'b1;
        chk("t4b_timeout_c0", 0, timeout, 1'b1);
        tick();
        start = 1'b0;
        chk("t4b_timeout_c1", 1, timeout, 1'b0);
        tick();
        abort = 1'b1;
        chk("t4b_rst_n_c2", 2, target_rst_n, 1'b0);
        tick();
        abort = 1'b0;
        chk("t4b_rst_n_abort", 3, target_rst_n, 1'b1);
        chk("t4b_busy_abort", 3, busy, 1'b0);
        chk("t4b_state_abort", 3, state_dbg, 3'd0);
        tick();

        // Abort in 2nd GLITCH cycle of a w=10 pulse (glitch starts at 8)
        delay_cfg = 32'd3; width_cfg = 32'd10;
        for (int c = 0; c <= 9; c++) begin
            start = (c == 0);
            abort = (c == 9);
            if (c >= 8) chk("t5_glitch_pre", c, glitch_out, 1'b1);
            tick();
        end
        start = 1'b0; abort = 1'b0;
        for (int c = 10; c <= 16; c++) begin
            chk("t5_glitch", c, glitch_out, 1'b0);
            chk("t5_busy", c, busy, 1'b0);
            chk("t5_done", c, done, 1'b0);
            chk("t5_state", c, state_dbg, 3'd0);
            tick();
        end
        chk("t5_count", 0, glitch_count, exp_count);

        // start and abort together in IDLE: stays idle
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("idle_abort_state", 1, state_dbg, 3'd0);
        chk("idle_abort_busy", 1, busy, 1'b0);
        chk("idle_abort_rst_n", 1, target_rst_n, 1'b1);
        tick();

        // rst mid-RESET releases the target on the next edge
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t5r_rst_n_pre", 2, target_rst_n, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5r_rst_n", 3, target_rst_n, 1'b1);
        chk("t5r_busy", 3, busy, 1'b0);
        chk("t5r_state", 3, state_dbg, 3'd0);
        exp_count = 0;
        chk("t5r_count", 3, glitch_count, exp_count);
        tick();

        // Two back-to-back shots
        shot_plain(1, 3, -1);
        shot_plain(2, 1, -1);
        exp_count = 2;
        chk("t6_b2b_count", 0, glitch_count, exp_count);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
